// File: rtl/controlador_de_clock.sv
// -----------------------------------------------------------------------------
// controlador_de_clock
//
// Clock-enable controller placed between the board-clock divider and the
// processor core. Everything runs on clockPlaca; the processor advances one
// step for every cycle in which habilitaClock is high.
//
// Modes:
//   PASSO (00) single-step: one enable pulse per debounced press of botaoPasso
//   EXEC  (01) free-running: one enable pulse per clockLento period
//   HALT  (10) halted on the processor's halt request until chaveModo = 0
//
// Ports:
//   clockPlaca      in   1               board clock (only clock)
//   resetPlaca      in   1               asynchronous reset, active low
//   botaoPasso      in   1               raw step pushbutton, 1 = pressed
//   chaveModo       in   1               raw mode switch, 0 = step, 1 = run
//   halt            in   1               synchronous halt request (level)
//   habilitaClock   out  1               one-cycle processor enable
//   clockLento      out  1               square wave, period 2*(DIVISOR+1)
//   estado          out  2               FSM state for LEDs
//   contadorPassos  out  LARGURA_PASSOS  number of enable pulses issued
//
// Build option:
//   CONTADOR_PASSOS_EN  when defined, the step counter is built; otherwise
//                       contadorPassos is tied to zero.
// -----------------------------------------------------------------------------
module controlador_de_clock #(
    parameter int DIVISOR         = 100,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LARGURA_PASSOS  = 16
) (
    input  logic                      clockPlaca,
    input  logic                      resetPlaca,
    input  logic                      botaoPasso,
    input  logic                      chaveModo,
    input  logic                      halt,
    output logic                      habilitaClock,
    output logic                      clockLento,
    output logic [1:0]                estado,
    output logic [LARGURA_PASSOS-1:0] contadorPassos
);

    // Divider counter covers the whole legal DIVISOR range.
    localparam int                DIV_W  = 24;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIVISOR);

    // Debounce counter must be able to hold DEBOUNCE_CYCLES itself.
    localparam int                DEB_W  = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        PASSO = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } estado_t;

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0] contador_div_r;
    logic             clock_lento_r;
    logic             tick_s;
    logic             sobe_lento_s;

    logic [1:0]       botao_sinc_r;
    logic [1:0]       modo_sinc_r;
    logic             botao_s;
    logic             modo_s;

    logic [DEB_W-1:0] contador_deb_r;
    logic             nivel_deb_r;
    logic             nivel_deb_ant_r;
    logic             pedido_s;

    estado_t          estado_r;
    logic             habilita_r;

    // ---------------------------------------------------------------------
    // Free-running divider
    // ---------------------------------------------------------------------
    assign tick_s       = (contador_div_r == DIV_TC);
    // A tick that is about to drive clockLento from 0 to 1.
    assign sobe_lento_s = tick_s & ~clock_lento_r;

    // Divider counter and slow square wave; runs in every FSM state.
    always_ff @(posedge clockPlaca or negedge resetPlaca) begin
        if (!resetPlaca) begin
            contador_div_r <= {DIV_W{1'b0}};
            clock_lento_r  <= 1'b0;
        end else if (tick_s) begin
            contador_div_r <= {DIV_W{1'b0}};
            clock_lento_r  <= ~clock_lento_r;
        end else begin
            contador_div_r <= contador_div_r + DIV_W'(1);
            clock_lento_r  <= clock_lento_r;
        end
    end

    // ---------------------------------------------------------------------
    // Input synchronizers (two flops each)
    // ---------------------------------------------------------------------
    // Bring the asynchronous button and mode switch into the clock domain.
    always_ff @(posedge clockPlaca or negedge resetPlaca) begin
        if (!resetPlaca) begin
            botao_sinc_r <= 2'b00;
            modo_sinc_r  <= 2'b00;
        end else begin
            botao_sinc_r <= {botao_sinc_r[0], botaoPasso};
            modo_sinc_r  <= {modo_sinc_r[0], chaveModo};
        end
    end

    assign botao_s = botao_sinc_r[1];
    // The mode switch is a slow manual control and is used without debounce.
    assign modo_s  = modo_sinc_r[1];

    // ---------------------------------------------------------------------
    // Button debounce
    // ---------------------------------------------------------------------
    // The counter measures how long the synchronized button has disagreed
    // with the accepted level; any agreeing sample restarts the measurement,
    // so a bounce back to the old level discards the partial count.
    always_ff @(posedge clockPlaca or negedge resetPlaca) begin
        if (!resetPlaca) begin
            contador_deb_r <= {DEB_W{1'b0}};
            nivel_deb_r    <= 1'b0;
        end else if (botao_s == nivel_deb_r) begin
            contador_deb_r <= {DEB_W{1'b0}};
            nivel_deb_r    <= nivel_deb_r;
        end else if (contador_deb_r == DEB_TC) begin
            contador_deb_r <= {DEB_W{1'b0}};
            nivel_deb_r    <= botao_s;
        end else begin
            contador_deb_r <= contador_deb_r + DEB_W'(1);
            nivel_deb_r    <= nivel_deb_r;
        end
    end

    // Previous debounced level, used for rising-edge detection.
    always_ff @(posedge clockPlaca or negedge resetPlaca) begin
        if (!resetPlaca) begin
            nivel_deb_ant_r <= 1'b0;
        end else begin
            nivel_deb_ant_r <= nivel_deb_r;
        end
    end

    // One-cycle step request on each accepted press. It is not stored: if
    // the FSM cannot use it on this cycle it is lost.
    assign pedido_s = nivel_deb_r & ~nivel_deb_ant_r;

    // ---------------------------------------------------------------------
    // Mode FSM with registered enable
    // ---------------------------------------------------------------------
    // The enable is cleared by default every cycle, so it can only ever be a
    // single cycle wide, and no pulse is issued on a state transition.
    always_ff @(posedge clockPlaca or negedge resetPlaca) begin
        if (!resetPlaca) begin
            estado_r   <= PASSO;
            habilita_r <= 1'b0;
        end else begin
            habilita_r <= 1'b0;
            case (estado_r)
                PASSO: begin
                    if (modo_s) begin
                        estado_r <= EXEC;
                    end else if (pedido_s && !halt) begin
                        estado_r   <= PASSO;
                        habilita_r <= 1'b1;
                    end else begin
                        estado_r <= PASSO;
                    end
                end
                EXEC: begin
                    // Mode switch outranks halt, halt outranks the tick.
                    if (!modo_s) begin
                        estado_r <= PASSO;
                    end else if (halt) begin
                        estado_r <= HALT;
                    end else if (sobe_lento_s) begin
                        estado_r   <= EXEC;
                        habilita_r <= 1'b1;
                    end else begin
                        estado_r <= EXEC;
                    end
                end
                HALT: begin
                    if (!modo_s) begin
                        estado_r <= PASSO;
                    end else begin
                        estado_r <= HALT;
                    end
                end
                default: begin
                    estado_r <= PASSO;
                end
            endcase
        end
    end

    assign habilitaClock = habilita_r;
    assign clockLento    = clock_lento_r;
    assign estado        = estado_r;

    // ---------------------------------------------------------------------
    // Step counter
    // ---------------------------------------------------------------------
`ifdef CONTADOR_PASSOS_EN
    logic [LARGURA_PASSOS-1:0] contador_passos_r;

    // Count issued enable pulses; wraps naturally at all-ones.
    always_ff @(posedge clockPlaca or negedge resetPlaca) begin
        if (!resetPlaca) begin
            contador_passos_r <= {LARGURA_PASSOS{1'b0}};
        end else if (habilita_r) begin
            contador_passos_r <= contador_passos_r + LARGURA_PASSOS'(1);
        end else begin
            contador_passos_r <= contador_passos_r;
        end
    end

    assign contadorPassos = contador_passos_r;
`else
    assign contadorPassos = {LARGURA_PASSOS{1'b0}};
`endif

endmodule

// File: tb/tb_controlador_de_clock.sv
// -----------------------------------------------------------------------------
// Self-checking bench for controlador_de_clock with DIVISOR=3,
// DEBOUNCE_CYCLES=4, LARGURA_PASSOS=4. Expected enable pulses are pushed to a
// queue (absolute cycle numbers) when stimulus is applied; a monitor pops and
// compares them whenever habilitaClock is seen high.
// -----------------------------------------------------------------------------
module tb_controlador_de_clock;

    localparam int DIV = 3;
    localparam int DEB = 4;
    localparam int LP  = 4;

`ifdef CONTADOR_PASSOS_EN
    localparam int CONTA_RUN  = 5;
    localparam int CONTA_WRAP = 1;
`else
    localparam int CONTA_RUN  = 0;
    localparam int CONTA_WRAP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          botao;
    logic          chave;
    logic          halt;
    logic          habilitaClock;
    logic          clockLento;
    logic [1:0]    estado;
    logic [LP-1:0] contadorPassos;

    controlador_de_clock #(
        .DIVISOR        (DIV),
        .DEBOUNCE_CYCLES(DEB),
        .LARGURA_PASSOS (LP)
    ) dut (
        .clockPlaca    (clk),
        .resetPlaca    (rst_n),
        .botaoPasso    (botao),
        .chaveModo     (chave),
        .halt          (halt),
        .habilitaClock (habilitaClock),
        .clockLento    (clockLento),
        .estado        (estado),
        .contadorPassos(contadorPassos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    int   base   = 0;
    int   exp_q[$];
    int   perdido;
    logic hab_prev = 1'b0;

    typedef struct {
        int duracao;   // negedges the button is held
        int quique;    // 1: button drops for one cycle on the third cycle
        int com_halt;  // 1: halt held high during the press
        int pulsos;    // expected pulses (0 or 1)
        int atraso;    // pulse cycle relative to first pressed edge
    } vetor_t;

    vetor_t tab[5];

    task automatic check(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string nome);
        check({nome, "_hab"}, int'(habilitaClock), 0);
        check({nome, "_lento"}, int'(clockLento), 0);
        check({nome, "_estado"}, int'(estado), 0);
        check({nome, "_contador"}, int'(contadorPassos), 0);
    endtask

    // Pulse scoreboard: every observed pulse must match the queue head.
    always @(posedge clk) begin
        #1;
        while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            perdido = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: no pulse at cycle %0d, expected habilitaClock=1", perdido);
        end
        if (habilitaClock) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: habilitaClock=1 at cycle %0d, expected 0", cyc);
            end else begin
                check("pulse_cycle", cyc, exp_q.pop_front());
            end
            if (hab_prev) begin
                checks++;
                errors++;
                $display("FAIL pulse_width: habilitaClock high two cycles at %0d, expected 1", cyc);
            end
        end
        hab_prev = habilitaClock;
    end

    initial begin
        tab[0] = '{duracao: 12, quique: 0, com_halt: 0, pulsos: 1, atraso: DEB + 3};
        tab[1] = '{duracao: 12, quique: 1, com_halt: 0, pulsos: 1, atraso: DEB + 6};
        tab[2] = '{duracao: DEB,     quique: 0, com_halt: 0, pulsos: 0, atraso: 0};
        tab[3] = '{duracao: DEB + 1, quique: 0, com_halt: 0, pulsos: 1, atraso: DEB + 3};
        tab[4] = '{duracao: 12, quique: 0, com_halt: 1, pulsos: 0, atraso: 0};

        rst_n = 1'b0;
        botao = 1'b0;
        chave = 1'b0;
        halt  = 1'b0;
        ciclos(3);
        check_zero("reset_init");

        // Release with run mode selected: pulses on rising ticks 4, 12, ...
        rst_n = 1'b1;
        chave = 1'b1;
        base  = cyc;
        for (int k = 0; k < 5; k++) exp_q.push_back(base + 4 + 8 * k);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("lento_edge%0d", e), int'(clockLento), (e == 4) ? 1 : 0);
        end
        while (cyc < base + 37) @(negedge clk);
        check("run_estado", int'(estado), 1);
        check("run_contador", int'(contadorPassos), CONTA_RUN);
        check("run_drained", exp_q.size(), 0);

        // Halt arrives on the edge of the next rising tick (44).
        while (cyc < base + 43) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        check("halt_estado", int'(estado), 2);
        check("halt_no_pulse", int'(habilitaClock), 0);
        botao = 1'b1;
        ciclos(10);
        botao = 1'b0;
        ciclos(20);
        check("halt_holds", int'(estado), 2);
        chave = 1'b0;
        ciclos(2);
        check("halt_modo_sync", int'(estado), 2);
        ciclos(1);
        check("halt_to_passo", int'(estado), 0);
        halt = 1'b0;
        ciclos(2);

        // Single-step vectors.
        for (int v = 0; v < 5; v++) begin
            halt = (tab[v].com_halt != 0);
            if (tab[v].pulsos == 1) exp_q.push_back(cyc + 1 + tab[v].atraso);
            for (int i = 0; i < tab[v].duracao; i++) begin
                botao = (tab[v].quique != 0 && i == 2) ? 1'b0 : 1'b1;
                @(negedge clk);
            end
            botao = 1'b0;
            ciclos(20);
            check($sformatf("step_vec%0d_drained", v), exp_q.size(), 0);
            check($sformatf("step_vec%0d_estado", v), int'(estado), 0);
            halt = 1'b0;
            ciclos(2);
        end

        // Priority: synchronized modo=0 and halt=1 meet on the same edge.
        while ((cyc - base) % 8 != 5) @(negedge clk);
        chave = 1'b1;
        ciclos(3);
        check("prio_exec", int'(estado), 1);
        chave = 1'b0;
        ciclos(2);
        check("prio_still_exec", int'(estado), 1);
        halt = 1'b1;
        ciclos(1);
        check("prio_modo_beats_halt", int'(estado), 0);
        halt = 1'b0;
        ciclos(2);
        check("prio_settled", int'(estado), 0);

        // Reset asserted in the middle of an enable pulse.
        while ((cyc - base) % 8 != 5) @(negedge clk);
        chave = 1'b1;
        exp_q.push_back(cyc + 7);
        while (cyc < exp_q[0] - 1) @(negedge clk);
        @(posedge clk);
        #2;
        check("pulse_before_reset", int'(habilitaClock), 1);
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        ciclos(3);
        check_zero("reset_hold");

        // Restart in run mode and issue 17 pulses to wrap the counter.
        rst_n = 1'b1;
        base  = cyc;
        for (int k = 0; k < 17; k++) exp_q.push_back(base + 4 + 8 * k);
        while (cyc < base + 133) @(negedge clk);
        check("wrap_contador", int'(contadorPassos), CONTA_WRAP);
        check("wrap_drained", exp_q.size(), 0);
        chave = 1'b0;
        ciclos(6);
        check("final_estado", int'(estado), 0);
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
